// File: rtl/fifo_gen2_if.sv
// Handshake/status bundle for fifo_gen2: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface fifo_gen2_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_in;
  logic             flush;
  logic             clr_err;
  logic [AW:0]      population;
  logic [AW:0]      free_space;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, rd_en, data_in, flush, clr_err,
    input  population, free_space, data_out, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, data_in, flush, clr_err,
    output population, free_space, data_out, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_gen2.sv
// Single-clock parametrised FIFO with level flags, sticky error flags and flush.
// Define FIFO_GEN2_FWFT_EN for first-word-fall-through read data.
module fifo_gen2 #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic       clk,
  input logic       rst,
  fifo_gen2_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]      population, pop_nxt;
  logic [WIDTH-1:0] data_out, data_out_nxt;
  logic             overflow, underflow;
  logic             full, empty;
  logic             wr_ok, rd_ok, ovf_set, udf_set;

  // Every status output is a function of the registered population only.
  assign full  = (population == DEPTH_C);
  assign empty = (population == '0);

  assign bus.population   = population;
  assign bus.free_space   = DEPTH_C - population;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (population >= AF_C);
  assign bus.almost_empty = (population <= AE_C);
  assign bus.data_out     = data_out;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

  // NOTE: every variable is given a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    pop_nxt    = population;
    if (bus.flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      pop_nxt    = '0;
    end else begin
      // A full FIFO can still take a write when a read frees a slot at the same edge.
      rd_ok   = bus.rd_en && !empty;
      wr_ok   = bus.wr_en && (!full || rd_ok);
      ovf_set = bus.wr_en && !wr_ok;
      udf_set = bus.rd_en && empty;
      if (wr_ok) wr_ptr_nxt = wr_ptr + AW'(1);
      if (rd_ok) rd_ptr_nxt = rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   pop_nxt = population + (AW+1)'(1);
        2'b01:   pop_nxt = population - (AW+1)'(1);
        default: pop_nxt = population;
      endcase
    end
  end

`ifdef FIFO_GEN2_FWFT_EN
  // Present the head of the queue as it will stand after this edge; a word
  // being written into the head slot right now is forwarded from data_in.
  always_comb begin
    data_out_nxt = '0;
    if (pop_nxt != '0) begin
      if (wr_ok && (wr_ptr == rd_ptr_nxt)) data_out_nxt = bus.data_in;
      else                                 data_out_nxt = mem[rd_ptr_nxt];
    end
  end
`else
  always_comb begin
    data_out_nxt = data_out;
    if (rd_ok) data_out_nxt = mem[rd_ptr];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      population <= '0;
      data_out   <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      population <= pop_nxt;
      data_out   <= data_out_nxt;
      // A fresh error in the clear cycle wins over clr_err.
      overflow   <= ovf_set | (overflow  & ~bus.clr_err);
      underflow  <= udf_set | (underflow & ~bus.clr_err);
    end
  end

  // NOTE: the storage array has no reset; only pointers and population define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.data_in;
  end
endmodule

// File: tb/tb_fifo_gen2.sv
// Directed bench for fifo_gen2 (DEPTH=8, WIDTH=16, AF_LEVEL=4, AE_LEVEL=4):
// read data is checked by a monitor against a queue of expected words.
module tb_fifo_gen2;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [WIDTH-1:0] exp_q [$];

  fifo_gen2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_gen2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; inputs change at the falling edge.
  task automatic cycle(input logic wr, input logic rd, input logic [WIDTH-1:0] din,
                       input logic fl, input logic ce);
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.data_in = din;
    bus.flush   = fl;
    bus.clr_err = ce;
    @(negedge clk);
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    cycle(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input logic [WIDTH-1:0] expect_word);
    exp_q.push_back(expect_word);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " population"},   32'(bus.population), 32'd0);
    check({tag, " free_space"},   32'(bus.free_space), 32'd8);
    check({tag, " empty"},        32'(bus.empty), 32'd1);
    check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
    check({tag, " full"},         32'(bus.full), 32'd0);
    check({tag, " almost_full"},  32'(bus.almost_full), 32'd0);
    check({tag, " data_out"},     32'(bus.data_out), 32'd0);
    check({tag, " overflow"},     32'(bus.overflow), 32'd0);
    check({tag, " underflow"},    32'(bus.underflow), 32'd0);
  endtask

  // Monitor: an accepted read shows its word on data_out just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst && bus.rd_en && !bus.empty && !bus.flush) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got 0x%0h with no word expected at %0t", bus.data_out, $time);
        end else begin
          check("read_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    bus.flush = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle();
    check_reset_state("reset");

    // Fill to full, watching level flags on the way up.
    for (int i = 1; i <= 8; i++) begin
      push(WIDTH'(i));
      check("fill population",   32'(bus.population), 32'(i));
      check("fill almost_full",  32'(bus.almost_full), (i >= 4) ? 32'd1 : 32'd0);
      check("fill almost_empty", 32'(bus.almost_empty), (i <= 4) ? 32'd1 : 32'd0);
    end
    check("full flag",       32'(bus.full), 32'd1);
    check("full free_space", 32'(bus.free_space), 32'd0);
    check("full empty",      32'(bus.empty), 32'd0);

    push(16'hFFFF);
    check("overflow population", 32'(bus.population), 32'd8);
    check("overflow set",        32'(bus.overflow), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("overflow cleared",    32'(bus.overflow), 32'd0);

    // Drain in order, then one read too many.
    for (int i = 1; i <= 8; i++) pop(WIDTH'(i));
    check("drain empty", 32'(bus.empty), 32'd1);
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
    check("underflow set",      32'(bus.underflow), 32'd1);
    check("underflow data_out", 32'(bus.data_out), 32'h0008);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("underflow cleared",  32'(bus.underflow), 32'd0);

    // Wrap: pointers end at 6, then the next six words straddle index 7->0.
    for (int i = 0; i < 6; i++) push(WIDTH'(32'h20 + i));
    for (int i = 0; i < 6; i++) pop(WIDTH'(32'h20 + i));
    for (int i = 0; i < 6; i++) begin
      push(WIDTH'(32'hA + i));
      check("wrap fill population", 32'(bus.population), 32'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      pop(WIDTH'(32'hA + i));
      check("wrap drain population", 32'(bus.population), 32'(5 - i));
    end

    // Full with simultaneous read and write.
    for (int i = 1; i <= 8; i++) push(WIDTH'(i));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(WIDTH'(i + 1));
      cycle(1'b1, 1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
      check("rw full population", 32'(bus.population), 32'd8);
      check("rw full overflow",   32'(bus.overflow), 32'd0);
    end
    for (int i = 4; i <= 8; i++) pop(WIDTH'(i));
    for (int i = 0; i < 3; i++) pop(WIDTH'(32'h100 + i));
    check("rw drain empty", 32'(bus.empty), 32'd1);

    // Flush with a write in the same cycle.
    for (int i = 0; i < 5; i++) push(WIDTH'(32'h30 + i));
    cycle(1'b1, 1'b0, 16'h0055, 1'b1, 1'b0);
    check("flush population", 32'(bus.population), 32'd0);
    check("flush empty",      32'(bus.empty), 32'd1);
    check("flush overflow",   32'(bus.overflow), 32'd0);
    check("flush data_out",   32'(bus.data_out), 32'h0102);

    // Read and write into an empty FIFO: write lands, read is dropped.
    cycle(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
    check("empty rw population", 32'(bus.population), 32'd1);
    check("empty rw underflow",  32'(bus.underflow), 32'd1);
    pop(16'h0077);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a write burst.
    push(16'h0041);
    push(16'h0042);
    bus.wr_en = 1'b1; bus.data_in = 16'h0043;
    #2 rst = 1'b0;
    #1 check_reset_state("async rst");
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle();
    check_reset_state("post rst");

    repeat (2) idle();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_gen2.md
Name: fifo_gen2

Overview:
- Parametrised successor to the single-clock data/command/result FIFOs feeding and draining the PEA invoke and enable modules.
- Generalises width and depth and fixes the population range, so a full buffer reports DEPTH.
- Adds almost-full/almost-empty flags for enable logic, sticky overflow/underflow error flags, and a synchronous flush.
- Drop-in for the PEA input queues and the result/status output queues.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 1024, number of entries; must be a power of two and at least 2.
- AF_LEVEL, DEPTH-4, almost_full asserts when population >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when population <= AE_LEVEL.
- Derived AW = log2(DEPTH), the pointer width.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous active-low reset.
- wr_en, in, 1: write request.
- rd_en, in, 1: read (pop) request.
- data_in, in, WIDTH: write data.
- flush, in, 1: synchronous empty request.
- clr_err, in, 1: synchronous clear of the error flags.
- population, out, AW+1: number of stored words, 0..DEPTH.
- free_space, out, AW+1: DEPTH - population.
- data_out, out, WIDTH: read data.
- full, out, 1: population == DEPTH.
- empty, out, 1: population == 0.
- almost_full, out, 1: population >= AF_LEVEL.
- almost_empty, out, 1: population <= AE_LEVEL.
- overflow, out, 1: sticky; a write was dropped.
- underflow, out, 1: sticky; a read was dropped.

Behaviour:
- Reset (rst low, asynchronous): rd_ptr = wr_ptr = 0; population = 0; free_space = DEPTH; data_out = 0; empty = 1; full = 0; almost_empty = 1; almost_full = 0 (1 only if AF_LEVEL == 0); overflow = underflow = 0.
- Memory contents are not reset. Reset takes effect mid-operation with no pending state retained.
- Storage: DEPTH x WIDTH array; AW-bit read and write pointers wrap modulo DEPTH.
- The population register is updated +1 / -1 / 0 each cycle. Flags and free_space are derived from the registered population only (no combinational path from the enables).
- Write accepted when wr_en=1 and (not full, or rd_en=1 with not empty): mem[wr_ptr] <= data_in; wr_ptr++.
- Write dropped when wr_en=1, full and no accepted read: overflow <= 1; no state change.
- Read accepted when rd_en=1 and not empty: data_out <= mem[rd_ptr] at the same edge, i.e. 1-cycle latency after the rd_en sample edge; rd_ptr++. data_out holds its value otherwise.
- Read dropped when rd_en=1 and empty: underflow <= 1; data_out unchanged. A same-cycle write into an empty FIFO is still accepted; the read is not satisfied by it.
- Simultaneous accepted read and write: population unchanged; pointers both advance.
- Full and rd_en & wr_en: both accepted and no overflow. A write to the slot being read is legal because the read fetches the old word.
- Priority, highest first: rst, flush, normal operation.
- flush: pointers <= 0, population <= 0, data_out unchanged. wr_en/rd_en in the flush cycle are ignored and do not set error flags.
- clr_err: overflow <= 0 and underflow <= 0, unless a new error occurs in the same cycle, in which case the set wins.
- Pointer wrap: writing the word at index DEPTH-1 sets wr_ptr to 0; rd_ptr wraps likewise. Population stays exact across wrap.

Optional Feature:
- Macro FIFO_GEN2_FWFT_EN.
- When defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr] while not empty, registered so it is valid in the cycle empty deasserts.
  - rd_en acknowledges/pops, and data_out shows the next word after the edge.
  - When empty, data_out = 0.
- When undefined: the standard registered-read behaviour above applies.
- All flags, population and error behaviour are identical in both modes.

Test Plan:
- Reset then idle, DEPTH=8, WIDTH=16 -> population=0, free_space=8, empty=1, almost_empty=1, full=0, data_out=0.
- Write 0x0001..0x0008 into DEPTH=8 -> full=1, population=8, free_space=0, almost_full=1 from population 4 (AF_LEVEL=4). A 9th write of 0xFFFF leaves population 8 and sets overflow=1. clr_err clears it.
- Read 8 words -> data_out sequence 0x0001..0x0008, each one cycle after its rd_en. A 9th read leaves data_out=0x0008 and sets underflow=1.
- Wrap: fill 6, drain 6, then write 0xA..0xF and read -> correct order across index 7->0; population tracks 0..6.
- Full FIFO with wr_en=rd_en=1 for 3 cycles, writing 0x100..0x102 -> population stays 8, no overflow, reads return 0x0001..0x0003; a subsequent drain ends with 0x100..0x102.
- flush asserted with 5 words stored and wr_en=1 -> population=0, empty=1, no overflow. Async rst pulse mid-burst -> all outputs at reset values before the next edge.
